// File: rtl/mips_pkg.sv
// Shared register-file constants and the writeback selection record used by
// the writeback arbiter.
package mips_pkg;

    localparam int REG_W = 5;
    localparam int NREGS = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic             is_lat;
        logic [REG_W-1:0] rd;
    } wb_sel_t;

    // Register 0 is hardwired, so a result aimed there never reaches the file.
    function automatic logic reg_writable(input logic [REG_W-1:0] rd);
        return rd != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Long-latency result FIFO: DEPTH entries, extra pointer MSB distinguishes
// full from empty, no same-cycle bypass from push to pop.
module wb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int EW    = 37
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [EW-1:0] wdata_i,
    output logic [EW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wptr_q, rptr_q;
    logic [EW-1:0] mem_q [DEPTH];

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
        end else begin
            if (push_i && !full_o) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !rst) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_write_arbiter_chk.sv
// Flags an ALU write aimed at a register whose long-latency result is still
// outstanding (WAW ordering violation upstream).
module wb_write_arbiter_chk
    import mips_pkg::*;
(
    input logic             clk,
    input logic             rst,
    input logic             alu_valid,
    input logic [REG_W-1:0] alu_reg,
    input logic [NREGS-1:0] pending_i
);

    a_no_alu_waw: assert property (@(posedge clk) disable iff (rst)
        !(alu_valid && pending_i[alu_reg]));

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: ALU results take priority, long-latency results drain
// from a FIFO on ALU-idle cycles; tracks in-flight destinations for decode.
module wb_write_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [REG_W-1:0] alu_reg,
    input  logic [W-1:0]     alu_data,
    input  logic             lat_valid,
    output logic             lat_ready,
    input  logic [REG_W-1:0] lat_reg,
    input  logic [W-1:0]     lat_data,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [REG_W-1:0] issue_reg,
    input  logic [REG_W-1:0] q1_reg,
    input  logic [REG_W-1:0] q2_reg,
    output logic             q1_busy,
    output logic             q2_busy,
    output logic             regWrite,
    output logic [REG_W-1:0] writeReg,
    output logic [W-1:0]     writeData
);
    localparam int EW = REG_W + W;

    logic             fifo_full_s, fifo_empty_s, push_s, pop_s;
    logic [EW-1:0]    head_s;
    wb_sel_t          sel_s;
    logic [W-1:0]     sel_data_s;

    logic             regwrite_q, regwrite_d;
    logic [REG_W-1:0] writereg_q, writereg_d;
    logic [W-1:0]     writedata_q, writedata_d;
    logic             out_is_lat_q, out_is_lat_d;
    logic [NREGS-1:0] pending_q, pending_d;

    assign lat_ready   = !fifo_full_s && !rst;
    assign push_s      = lat_valid && lat_ready;
    assign pop_s       = !alu_valid && !fifo_empty_s && !rst;
    assign issue_ready = !pending_q[issue_reg] && !rst;
    assign q1_busy     = pending_q[q1_reg] && reg_writable(q1_reg);
    assign q2_busy     = pending_q[q2_reg] && reg_writable(q2_reg);

    assign regWrite  = regwrite_q;
    assign writeReg  = writereg_q;
    assign writeData = writedata_q;

    wb_result_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({lat_reg, lat_data}),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    wb_write_arbiter_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .pending_i (pending_q)
    );

    // Source selection: ALU first, then FIFO head, else idle.
    always_comb begin
        sel_s      = '{valid: 1'b0, is_lat: 1'b0, rd: REG_ZERO};
        sel_data_s = {W{1'b0}};
        if (alu_valid) begin
            sel_s      = '{valid: 1'b1, is_lat: 1'b0, rd: alu_reg};
            sel_data_s = alu_data;
        end else if (!fifo_empty_s) begin
            sel_s      = '{valid: 1'b1, is_lat: 1'b1, rd: head_s[EW-1:W]};
            sel_data_s = head_s[W-1:0];
        end else begin
            sel_s      = '{valid: 1'b0, is_lat: 1'b0, rd: REG_ZERO};
        end
    end

    // Next output and scoreboard state; idle cycles hold the last reg/data.
    always_comb begin
        regwrite_d   = sel_s.valid && reg_writable(sel_s.rd);
        out_is_lat_d = sel_s.valid && sel_s.is_lat;
        writereg_d   = writereg_q;
        writedata_d  = writedata_q;
        if (sel_s.valid) begin
            writereg_d  = sel_s.rd;
            writedata_d = sel_data_s;
        end else begin
            writereg_d  = writereg_q;
        end
        // Clear lands on the edge the registered long-latency write commits.
        pending_d = pending_q;
        if (out_is_lat_q) begin
            pending_d[writereg_q] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (issue_valid && issue_ready && reg_writable(issue_reg)) begin
            pending_d[issue_reg] = 1'b1;
        end else begin
            pending_d[REG_ZERO] = 1'b0;
        end
    end

    // Output registers and pending scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q   <= 1'b0;
            writereg_q   <= REG_ZERO;
            writedata_q  <= {W{1'b0}};
            out_is_lat_q <= 1'b0;
            pending_q    <= {NREGS{1'b0}};
        end else begin
            regwrite_q   <= regwrite_d;
            writereg_q   <= writereg_d;
            writedata_q  <= writedata_d;
            out_is_lat_q <= out_is_lat_d;
            pending_q    <= pending_d;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized + directed bench for wb_write_arbiter with a queue-based
// reference model and a scoreboard monitor on the register-file port.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lat_valid, issue_valid;
    logic [4:0]  alu_reg, lat_reg, issue_reg, q1_reg, q2_reg;
    logic [31:0] alu_data, lat_data;
    logic        lat_ready, issue_ready, q1_busy, q2_busy;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    wb_write_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .lat_valid(lat_valid), .lat_ready(lat_ready), .lat_reg(lat_reg), .lat_data(lat_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_reg(issue_reg),
        .q1_reg(q1_reg), .q2_reg(q2_reg), .q1_busy(q1_busy), .q2_busy(q2_busy),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [4:0] r; logic [31:0] d; } exp_t;
    typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;

    exp_t        exp_q[$];
    ent_t        mfifo[$];
    bit          mpend[32];
    int          clr_reg = -1;
    logic [4:0]  last_r = 5'd0;
    logic [31:0] last_d = 32'd0;
    int          checks = 0;
    int          passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // One clock cycle of stimulus: drive, check combinational outputs, advance model.
    task automatic cyc(input bit r, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ir, input logic [4:0] q1,
                       input logic [4:0] q2, output bit acc);
        bit   exp_lr, exp_ir, is_lat;
        exp_t e;
        ent_t h;
        @(negedge clk);
        rst = r; alu_valid = av; alu_reg = ar; alu_data = ad;
        lat_valid = lv; lat_reg = lr; lat_data = ld;
        issue_valid = iv; issue_reg = ir; q1_reg = q1; q2_reg = q2;
        #1;
        exp_lr = !r && (mfifo.size() < DEPTH);
        exp_ir = !r && !mpend[ir];
        check("lat_ready", {31'd0, lat_ready}, {31'd0, exp_lr});
        check("issue_ready", {31'd0, issue_ready}, {31'd0, exp_ir});
        check("q1_busy", {31'd0, q1_busy}, {31'd0, (q1 != 5'd0) && mpend[q1]});
        check("q2_busy", {31'd0, q2_busy}, {31'd0, (q2 != 5'd0) && mpend[q2]});
        acc = lv && exp_lr;
        if (r) begin
            mfifo.delete();
            foreach (mpend[i]) mpend[i] = 1'b0;
            clr_reg = -1;
            last_r = 5'd0; last_d = 32'd0;
            e = '{we: 1'b0, r: 5'd0, d: 32'd0};
        end else begin
            is_lat = 1'b0;
            if (av) begin
                last_r = ar; last_d = ad;
                e = '{we: (ar != 5'd0), r: ar, d: ad};
            end else if (mfifo.size() > 0) begin
                h = mfifo.pop_front();
                last_r = h.r; last_d = h.d; is_lat = 1'b1;
                e = '{we: (h.r != 5'd0), r: h.r, d: h.d};
            end else begin
                e = '{we: 1'b0, r: last_r, d: last_d};
            end
            if (acc) mfifo.push_back('{r: lr, d: ld});
            if (clr_reg >= 0) mpend[clr_reg] = 1'b0;
            if (iv && exp_ir && ir != 5'd0) mpend[ir] = 1'b1;
            clr_reg = is_lat ? int'(h.r) : -1;
        end
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: compare the registered write port once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("regWrite", {31'd0, regWrite}, {31'd0, e.we});
                check("writeReg", {27'd0, writeReg}, {27'd0, e.r});
                check("writeData", writeData, e.d);
            end
        end
    end

    initial begin
        bit          acc, have_offer, r, av, iv;
        logic [4:0]  ar, lr, ir;
        logic [31:0] ld;
        int          npush, alu_pct;
        rst = 1'b1; alu_valid = 1'b0; lat_valid = 1'b0; issue_valid = 1'b0;
        alu_reg = 5'd0; lat_reg = 5'd0; issue_reg = 5'd0; q1_reg = 5'd0; q2_reg = 5'd0;
        alu_data = 32'd0; lat_data = 32'd0;

        repeat (3) cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, acc);

        // ALU-only write.
        cyc(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, acc);

        // Issue r8, then its long-latency result; watch busy clear.
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8, 5'd0, acc);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD, 1'b0, 5'd8, 5'd8, 5'd8, acc);
        repeat (4) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd8, 5'd0, acc);

        // ALU busy 6 cycles while 5 results are offered; FIFO fills at DEPTH.
        npush = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b1, 5'(k + 1), 32'h100 + k, (npush < 5), 5'(12 + npush), 32'hA000 + npush,
                1'b0, 5'd0, 5'd0, 5'd0, acc);
            if (acc) npush++;
        end
        while (npush < 5) begin
            cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(12 + npush), 32'hA000 + npush,
                1'b0, 5'd0, 5'd0, 5'd0, acc);
            if (acc) npush++;
        end
        repeat (6) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, acc);

        // Destination 0: popped but not written, never pending.
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 5'd0, 5'd0, acc);
        repeat (3) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, acc);

        // Reset with 3 queued entries and r4 pending.
        cyc(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h9, 1'b1, 5'd4, 5'd4, 5'd0, acc);
        cyc(1'b0, 1'b1, 5'd7, 32'h78, 1'b1, 5'd10, 32'hA, 1'b0, 5'd0, 5'd4, 5'd0, acc);
        cyc(1'b0, 1'b1, 5'd7, 32'h79, 1'b1, 5'd11, 32'hB, 1'b0, 5'd0, 5'd4, 5'd0, acc);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd0, acc);
        repeat (3) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 5'd4, 5'd0, acc);

        // Randomized traffic with phases of varying ALU pressure.
        have_offer = 1'b0; lr = 5'd0; ld = 32'd0;
        for (int i = 0; i < 1500; i++) begin
            alu_pct = (i / 250) % 3 == 0 ? 85 : ((i / 250) % 3 == 1 ? 15 : 50);
            r  = ($urandom_range(0, 199) == 0);
            av = ($urandom_range(0, 99) < alu_pct);
            ar = 5'($urandom_range(0, 31));
            if (mpend[ar]) ar = 5'd0;
            if (!have_offer && $urandom_range(0, 99) < 60) begin
                have_offer = 1'b1;
                lr = 5'($urandom_range(0, 31));
                ld = $urandom;
            end
            iv = ($urandom_range(0, 99) < 30);
            ir = 5'($urandom_range(0, 31));
            cyc(r, av, ar, $urandom, have_offer, lr, ld, iv, ir,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), acc);
            if (acc) have_offer = 1'b0;
        end
        repeat (8) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, acc);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
